// File: rtl/bcd_disp_pkg.sv
// Shared types and 7-segment pattern constants for the BCD display scanner.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the outputs.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        SLOT_U = 2'd0,
        SLOT_T = 2'd1,
        SLOT_H = 2'd2
    } slot_t;

    typedef struct packed {
        logic [1:0] hunds;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd3_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Code fed to the decoder when the digit must render as a dash.
    localparam logic [3:0] CODE_DASH = 4'hF;

    function automatic logic [2:0] slot_enable(input slot_t s);
        case (s)
            SLOT_T:  return 3'b010;
            SLOT_H:  return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD code to active-high 7-segment pattern; codes above 9 give a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Three-digit multiplexed 7-segment scanner with dead time, leading-zero
// blanking and frame-aligned commit of new hunds/tens/units values.
module bcd_seg_scanner
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 16,
    parameter bit LZ_BLANK = 1'b1,
    parameter bit ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] hunds,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_tick
);

    localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);

    function automatic logic [6:0] seg_pol(input logic [6:0] pat_hi);
        return pat_hi ^ {7{ACT_LOW}};
    endfunction

    function automatic logic [2:0] an_pol(input logic [2:0] en_hi);
        return en_hi ^ {3{ACT_LOW}};
    endfunction

    logic [CNT_W-1:0] div_cnt;
    logic             div_wrap;
    slot_t            slot_q;
    slot_t            slot_d;

    logic  pending;
    logic  accept;
    logic  commit;
    bcd3_t pend;
    bcd3_t disp;

    logic       h_blank;
    logic       t_blank;
    logic       digit_lit;
    logic       in_window;
    logic [3:0] digit_code;
    logic [2:0] an_sel;
    logic [6:0] pattern;

    logic [6:0] seg_p1;
    logic [2:0] an_p1;

    // Slot timing: divider and slot state
    assign div_wrap = (div_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= SLOT_U;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        slot_d     = slot_q;
        frame_tick = 1'b0;
        case (slot_q)
            SLOT_U: if (div_wrap) slot_d = SLOT_T;
            SLOT_T: if (div_wrap) slot_d = SLOT_H;
            SLOT_H: begin
                frame_tick = div_wrap;
                if (div_wrap) slot_d = SLOT_U;
            end
            default: slot_d = SLOT_U;
        endcase
    end

    // Update handshake; disp only changes at a frame boundary
    assign in_ready = !pending;
    assign accept   = in_valid && !pending;
    assign commit   = frame_tick && pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (commit) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pend <= {hunds, tens, units};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp <= '0;
        end else if (commit) begin
            disp <= pend;
        end
    end

    // Digit select and blanking for the current slot
    always_comb begin
        h_blank    = LZ_BLANK && (disp.hunds == 2'd0);
        t_blank    = LZ_BLANK && (disp.hunds == 2'd0) && (disp.tens == 4'd0);
        digit_code = disp.units;
        digit_lit  = 1'b1;
        case (slot_q)
            SLOT_T: begin
                digit_code = disp.tens;
                digit_lit  = !t_blank;
            end
            SLOT_H: begin
                // hunds==3 is out of range for a 0-255 source; show it as a dash
                digit_code = (disp.hunds == 2'd3) ? CODE_DASH : {2'b00, disp.hunds};
                digit_lit  = !h_blank;
            end
            default: begin
                digit_code = disp.units;
                digit_lit  = 1'b1;
            end
        endcase
    end

    assign an_sel    = slot_enable(slot_q);
    assign in_window = (div_cnt >= CNT_DEAD);

    bcd_to_seg7 u_dec (
        .code    (digit_code),
        .pattern (pattern)
    );

    // Output register stage (p1)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_p1  <= an_pol(3'b000);
            seg_p1 <= seg_pol(SEG_BLANK);
        end else if (in_window && digit_lit) begin
            an_p1  <= an_pol(an_sel);
            seg_p1 <= seg_pol(pattern);
        end else begin
            an_p1  <= an_pol(3'b000);
            seg_p1 <= seg_pol(SEG_BLANK);
        end
    end

    assign seg = seg_p1;
    assign an  = an_p1;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner: two instances (leading-zero blanking on/off)
// checked every cycle against a frame-level display model plus literal pins.
module tb_bcd_seg_scanner;

    localparam int SD   = 8;
    localparam int DEAD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] hunds;
    logic [3:0] tens;
    logic [3:0] units;

    logic       in_ready,   in_ready_nz;
    logic [6:0] seg,        seg_nz;
    logic [2:0] an,         an_nz;
    logic       frame_tick, frame_tick_nz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_seg_scanner #(.SCAN_DIV(SD), .DEAD_CYC(DEAD), .LZ_BLANK(1'b1), .ACT_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .hunds(hunds), .tens(tens), .units(units),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    bcd_seg_scanner #(.SCAN_DIV(SD), .DEAD_CYC(DEAD), .LZ_BLANK(1'b0), .ACT_LOW(1'b1)) dut_nz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nz),
        .hunds(hunds), .tens(tens), .units(units),
        .seg(seg_nz), .an(an_nz), .frame_tick(frame_tick_nz)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- display model ----------------
    localparam logic [6:0] DIGIT_PAT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] glyph(input int code);
        return (code >= 0 && code <= 9) ? DIGIT_PAT[code] : 7'h40;
    endfunction

    // Returns {an, seg} in active-low form for slot s, position p in the slot.
    function automatic logic [9:0] render(input bit lz, input int s, input int p,
                                          input int h, input int tn, input int u);
        int         code;
        bit         lit;
        logic [2:0] a;
        logic [6:0] g;
        case (s)
            0:       begin code = u;  lit = 1'b1; end
            1:       begin code = tn; lit = !(lz && h == 0 && tn == 0); end
            default: begin code = (h == 3) ? 10 : h; lit = !(lz && h == 0); end
        endcase
        a = 3'b000;
        g = 7'h00;
        if (p >= DEAD && lit) begin
            a = 3'b001 << s;
            g = glyph(code);
        end
        return {~a, ~g};
    endfunction

    int         t = 0;
    bit         started = 1'b0;
    int         mh = 0, mt = 0, mu = 0, mp = 0;
    int         ph = 0, pt = 0, pu = 0;
    int         ms, mpos;
    bit         mtick, macc;
    logic [9:0] exp_lz = 10'h3FF;
    logic [9:0] exp_nz = 10'h3FF;

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            t = 0; mp = 0; mh = 0; mt = 0; mu = 0;
            exp_lz = 10'h3FF;
            exp_nz = 10'h3FF;
        end else begin
            ms     = (t / SD) % 3;
            mpos   = t % SD;
            exp_lz = render(1'b1, ms, mpos, mh, mt, mu);
            exp_nz = render(1'b0, ms, mpos, mh, mt, mu);
            mtick  = (ms == 2) && (mpos == SD - 1);
            macc   = in_valid && (mp == 0);
            if (mtick && mp != 0) begin
                mh = ph; mt = pt; mu = pu; mp = 0;
            end
            if (macc) begin
                ph = int'(hunds); pt = int'(tens); pu = int'(units); mp = 1;
            end
            t = t + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("an_lz",     an,            exp_lz[9:7]);
            chk("seg_lz",    seg,           exp_lz[6:0]);
            chk("an_nz",     an_nz,         exp_nz[9:7]);
            chk("seg_nz",    seg_nz,        exp_nz[6:0]);
            chk("ready_lz",  in_ready,      mp == 0);
            chk("ready_nz",  in_ready_nz,   mp == 0);
            chk("tick_lz",   frame_tick,    ((t / SD) % 3 == 2) && (t % SD == SD - 1));
            chk("tick_nz",   frame_tick_nz, ((t / SD) % 3 == 2) && (t % SD == SD - 1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic offer(input int h, input int tn, input int u);
        hunds    = 2'(h);
        tens     = 4'(tn);
        units    = 4'(u);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Advance to the negedge where the scan is at slot s, position p.
    task automatic goto(input int s, input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = ((t / SD) % 3 == s) && (t % SD == p);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL goto_timeout actual=none expected=slot%0d_pos%0d", s, p);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; hunds = '0; tens = '0; units = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pin_rst_an",    an,         3'b111);
        chk("pin_rst_seg",   seg,        7'h7F);
        chk("pin_rst_ready", in_ready,   1'b1);
        chk("pin_rst_tick",  frame_tick, 1'b0);
        rst_n = 1'b1;

        // 125
        offer(1, 2, 5);
        @(negedge clk);
        chk("pin_125_busy", in_ready, 1'b0);
        goto(2, SD - 1);
        chk("pin_125_tick", frame_tick, 1'b1);
        goto(0, 2);
        chk("pin_125_dead_an", an, 3'b111);
        chk("pin_125_dead_seg", seg, 7'h7F);
        goto(0, 3);
        chk("pin_125_u_an", an, 3'b110);
        chk("pin_125_u_seg", seg, 7'h12);
        chk("pin_125_ready", in_ready, 1'b1);
        goto(1, 3);
        chk("pin_125_t_an", an, 3'b101);
        chk("pin_125_t_seg", seg, 7'h24);
        goto(2, 3);
        chk("pin_125_h_an", an, 3'b011);
        chk("pin_125_h_seg", seg, 7'h79);

        // 003 with and without blanking
        offer(0, 0, 3);
        goto(2, SD - 1);
        goto(0, 3);
        chk("pin_003_u_seg", seg, 7'h30);
        chk("pin_003_u_an", an, 3'b110);
        goto(1, 3);
        chk("pin_003_t_an_lz", an, 3'b111);
        chk("pin_003_t_seg_nz", seg_nz, 7'h40);
        goto(2, 3);
        chk("pin_003_h_an_lz", an, 3'b111);
        chk("pin_003_h_an_nz", an_nz, 3'b011);

        // tens out of range
        offer(0, 4'hA, 4);
        goto(2, SD - 1);
        goto(0, 3);
        chk("pin_0a4_u_seg", seg_nz, 7'h19);
        goto(1, 3);
        chk("pin_0a4_t_seg", seg_nz, 7'h3F);
        chk("pin_0a4_t_an", an_nz, 3'b101);

        // second offer while busy is dropped
        offer(1, 0, 0);
        offer(2, 0, 0);
        goto(2, SD - 1);
        goto(2, 3);
        chk("pin_100_h_seg", seg, 7'h79);
        chk("pin_100_h_an", an, 3'b011);

        // accept on the frame_tick cycle commits one frame later
        goto(2, SD - 1);
        chk("pin_tickacc_ready", in_ready, 1'b1);
        offer(0, 0, 7);
        goto(0, 3);
        chk("pin_tickacc_old", seg, 7'h40);
        chk("pin_tickacc_busy", in_ready, 1'b0);
        goto(2, SD - 1);
        goto(0, 3);
        chk("pin_tickacc_new", seg, 7'h78);

        // hunds==3 and units out of range
        offer(3, 9, 4'hF);
        goto(2, SD - 1);
        goto(0, 3);
        chk("pin_39f_u_seg", seg, 7'h3F);
        goto(2, 3);
        chk("pin_39f_h_seg", seg, 7'h3F);
        chk("pin_39f_h_an", an, 3'b011);

        // reset mid-frame with an update pending
        offer(2, 2, 2);
        goto(2, 4);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("pin_mrst_an", an, 3'b111);
        chk("pin_mrst_seg", seg, 7'h7F);
        chk("pin_mrst_ready", in_ready, 1'b1);
        goto(0, 3);
        chk("pin_mrst_u_seg", seg, 7'h40);
        chk("pin_mrst_u_an", an, 3'b110);
        goto(2, SD - 1);
        goto(0, 3);
        chk("pin_mrst_lost", seg, 7'h40);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
